// File: rtl/shape_grid_pkg.sv
// +----------------------------------------------------------------------+
// | shape_grid_pkg : grid geometry, shape indices and FSM encoding       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package shape_grid_pkg;

  localparam int GRID_COLS   = 3;
  localparam int GRID_ROWS   = 3;
  localparam int SHAPE_IDX_W = 4;
  localparam int SHAPE_COUNT = GRID_COLS * GRID_ROWS;

  typedef logic [1:0] grid_pos_t;

  localparam grid_pos_t ROW_MAX = grid_pos_t'(GRID_ROWS - 1);
  localparam grid_pos_t COL_MAX = grid_pos_t'(GRID_COLS - 1);

  localparam logic [SHAPE_IDX_W-1:0] CIRCULO    = 4'd0;
  localparam logic [SHAPE_IDX_W-1:0] CUADRADO   = 4'd1;
  localparam logic [SHAPE_IDX_W-1:0] TRIANGULO  = 4'd2;
  localparam logic [SHAPE_IDX_W-1:0] OVALO      = 4'd3;
  localparam logic [SHAPE_IDX_W-1:0] RECTANGULO = 4'd4;
  localparam logic [SHAPE_IDX_W-1:0] ROMBO      = 4'd5;
  localparam logic [SHAPE_IDX_W-1:0] HEXAGONO   = 4'd6;
  localparam logic [SHAPE_IDX_W-1:0] PENTAGONO  = 4'd7;
  localparam logic [SHAPE_IDX_W-1:0] ESTRELLA   = 4'd8;

  localparam logic [0:0] SELECT    = 1'b0;
  localparam logic [0:0] CONFIRMED = 1'b1;

  function automatic logic [SHAPE_IDX_W-1:0] grid_index(input grid_pos_t row, input grid_pos_t col);
    return SHAPE_IDX_W'(row) * SHAPE_IDX_W'(GRID_COLS) + SHAPE_IDX_W'(col);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// +----------------------------------------------------------------------+
// | btn_debounce : 2-FF synchroniser, debounce counter, press pulse      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_fill;
  logic             r_armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_cnt      <= '0;
      r_fill     <= 2'b00;
      r_armed    <= 1'b0;
      pulse      <= 1'b0;
    end else begin
      r_sync1    <= btn_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_fill     <= {r_fill[0], 1'b1};
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Arm only once the synchroniser has refilled and shows a released
      // button, so a button held through reset cannot fire a press.
      if (r_fill[1] && !r_sync2 && !r_stable) begin
        r_armed <= 1'b1;
      end
      pulse <= r_stable & ~r_stable_d & r_armed;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shape_cursor_ctrl.sv
// +----------------------------------------------------------------------+
// | shape_cursor_ctrl : buttons -> 3x3 cursor, one-hot shape selects,    |
// | confirm FSM. Define SHAPE_CURSOR_WRAP_EN to wrap at grid edges.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module shape_cursor_ctrl
  import shape_grid_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_enter,
  output logic                   circulo,
  output logic                   cuadrado,
  output logic                   triangulo,
  output logic                   ovalo,
  output logic                   rectangulo,
  output logic                   rombo,
  output logic                   hexagono,
  output logic                   pentagono,
  output logic                   estrella,
  output logic                   enter,
  output logic [SHAPE_IDX_W-1:0] sel_index
);

`ifdef SHAPE_CURSOR_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  function automatic grid_pos_t step_dec(input grid_pos_t v, input grid_pos_t vmax);
    if (v == 2'd0) return WRAP ? vmax : 2'd0;
    return v - 2'd1;
  endfunction

  function automatic grid_pos_t step_inc(input grid_pos_t v, input grid_pos_t vmax);
    if (v == vmax) return WRAP ? 2'd0 : vmax;
    return v + 2'd1;
  endfunction

  logic w_up, w_down, w_left, w_right, w_enter;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_up (
    .clk(clk), .reset(reset), .btn_raw(btn_up), .pulse(w_up));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_down (
    .clk(clk), .reset(reset), .btn_raw(btn_down), .pulse(w_down));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_left (
    .clk(clk), .reset(reset), .btn_raw(btn_left), .pulse(w_left));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_right (
    .clk(clk), .reset(reset), .btn_raw(btn_right), .pulse(w_right));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_enter (
    .clk(clk), .reset(reset), .btn_raw(btn_enter), .pulse(w_enter));

  grid_pos_t               r_row, r_col, w_row_nx, w_col_nx;
  logic [0:0]              r_state, w_state_nx;
  logic [SHAPE_COUNT-1:0]  r_shape;
  logic [SHAPE_IDX_W-1:0]  w_idx_nx;

  // One action per cycle: enter > up > down > left > right.
  always_comb begin
    w_row_nx   = r_row;
    w_col_nx   = r_col;
    w_state_nx = r_state;
    if (w_enter) begin
      w_state_nx = (r_state == SELECT) ? CONFIRMED : SELECT;
    end else if (r_state == SELECT) begin
      if (w_up)         w_row_nx = step_dec(r_row, ROW_MAX);
      else if (w_down)  w_row_nx = step_inc(r_row, ROW_MAX);
      else if (w_left)  w_col_nx = step_dec(r_col, COL_MAX);
      else if (w_right) w_col_nx = step_inc(r_col, COL_MAX);
    end
    w_idx_nx = grid_index(w_row_nx, w_col_nx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row     <= 2'd0;
      r_col     <= 2'd0;
      r_state   <= SELECT;
      enter     <= 1'b0;
      sel_index <= CIRCULO;
      r_shape   <= SHAPE_COUNT'(1);
    end else begin
      r_row     <= w_row_nx;
      r_col     <= w_col_nx;
      r_state   <= w_state_nx;
      enter     <= (w_state_nx == CONFIRMED);
      sel_index <= w_idx_nx;
      r_shape   <= SHAPE_COUNT'(1) << w_idx_nx;
    end
  end

  assign circulo    = r_shape[CIRCULO];
  assign cuadrado   = r_shape[CUADRADO];
  assign triangulo  = r_shape[TRIANGULO];
  assign ovalo      = r_shape[OVALO];
  assign rectangulo = r_shape[RECTANGULO];
  assign rombo      = r_shape[ROMBO];
  assign hexagono   = r_shape[HEXAGONO];
  assign pentagono  = r_shape[PENTAGONO];
  assign estrella   = r_shape[ESTRELLA];

endmodule

`default_nettype wire

// File: tb/tb_shape_cursor_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_shape_cursor_ctrl : scoreboard bench with a grid-level cursor model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_shape_cursor_ctrl;

  localparam int D   = 4;
  localparam int GAP = 14;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic b_up = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0, b_enter = 1'b0;
  logic circulo, cuadrado, triangulo, ovalo, rectangulo, rombo;
  logic hexagono, pentagono, estrella, enter;
  logic [3:0] sel_index;

  shape_cursor_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .btn_up(b_up), .btn_down(b_down), .btn_left(b_left), .btn_right(b_right), .btn_enter(b_enter),
    .circulo(circulo), .cuadrado(cuadrado), .triangulo(triangulo),
    .ovalo(ovalo), .rectangulo(rectangulo), .rombo(rombo),
    .hexagono(hexagono), .pentagono(pentagono), .estrella(estrella),
    .enter(enter), .sel_index(sel_index));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int idx; bit en; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference cursor: plain grid coordinates and a confirmed flag.
  int m_row = 0, m_col = 0;
  bit m_conf = 1'b0;

  function automatic logic [8:0] shapes();
    return {estrella, pentagono, hexagono, rombo, rectangulo, ovalo, triangulo, cuadrado, circulo};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int move(input int v, input int d);
    int n = v + d;
`ifdef SHAPE_CURSOR_WRAP_EN
    return (n + 3) % 3;
`else
    return (n < 0) ? 0 : (n > 2) ? 2 : n;
`endif
  endfunction

  // mask bits: [4]=enter [3]=up [2]=down [1]=left [0]=right
  function automatic bit model_apply(input logic [4:0] m);
    int r0 = m_row, c0 = m_col;
    bit f0 = m_conf;
    if (m[4])       m_conf = !m_conf;
    else if (!m_conf) begin
      if (m[3])      m_row = move(m_row, -1);
      else if (m[2]) m_row = move(m_row, 1);
      else if (m[1]) m_col = move(m_col, -1);
      else if (m[0]) m_col = move(m_col, 1);
    end
    return (r0 != m_row) || (c0 != m_col) || (f0 != m_conf);
  endfunction

  task automatic drive(input logic [4:0] m);
    {b_enter, b_up, b_down, b_left, b_right} = m;
  endtask

  task automatic press(input logic [4:0] m, input int hold);
    exp_t e;
    @(negedge clk);
    drive(m);
    if (model_apply(m)) begin
      e.cyc = cyc + 1 + D + 4;
      e.idx = m_row * 3 + m_col;
      e.en  = m_conf;
      sb.push_back(e);
    end
    repeat (hold) @(negedge clk);
    drive(5'b0);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic glitch(input logic [4:0] m, input int len);
    @(negedge clk);
    drive(m);
    repeat (len) @(negedge clk);
    drive(5'b0);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    int idx = m_row * 3 + m_col;
    chk({tag, "_sel_index"}, 32'(sel_index), 32'(idx));
    chk({tag, "_enter"}, 32'(enter), 32'(m_conf));
    chk({tag, "_shapes"}, 32'(shapes()), 32'(9'd1 << idx));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected changes never observed", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset(input logic [4:0] keep);
    drain();
    mon_en = 1'b0;
    @(negedge clk);
    drive(keep);
    #2 reset = 1'b1;
    #1;
    chk("rst_sel_index", 32'(sel_index), 32'd0);
    chk("rst_enter", 32'(enter), 32'd0);
    chk("rst_shapes", 32'(shapes()), 32'h1);
    m_row = 0; m_col = 0; m_conf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  // Monitor: every output change must match the head of the scoreboard.
  initial begin
    logic [13:0] prev, cur;
    exp_t e;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      cur = {enter, sel_index, shapes()};
      if (mon_en && cur !== prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: got %0h was %0h (cycle %0d)", cur, prev, cyc);
        end else begin
          e = sb.pop_front();
          chk("change_cycle", 32'(cyc), 32'(e.cyc));
          chk("mon_sel_index", 32'(sel_index), 32'(e.idx));
          chk("mon_enter", 32'(enter), 32'(e.en));
          chk("mon_shapes", 32'(shapes()), 32'(9'd1 << e.idx));
        end
      end
      prev = cur;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_state("reset");
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    press(5'b00001, 20);
    press(5'b00001, 20);
    drain();
    check_state("right_x2");
    press(5'b00001, 20);
    drain();
    check_state("right_x3");

    do_reset(5'b0);
    glitch(5'b00100, 3);
    check_state("down_glitch");
    press(5'b00100, 10);
    drain();
    check_state("down");

    press(5'b00001, 12);
    press(5'b10000, 12);
    drain();
    check_state("confirm");
    press(5'b00010, 12);
    check_state("left_ignored");
    press(5'b10000, 12);
    press(5'b00010, 12);
    drain();
    check_state("unconfirm_left");

    press(5'b00001, 12);
    press(5'b11000, 12);
    drain();
    check_state("up_enter");

    // Hold right through a reset taken while confirmed.
    @(negedge clk);
    drive(5'b00001);
    void'(model_apply(5'b00001));
    repeat (20) @(negedge clk);
    do_reset(5'b00001);
    repeat (30) @(negedge clk);
    check_state("held_after_reset");
    drive(5'b0);
    repeat (GAP) @(negedge clk);
    press(5'b00001, 12);
    drain();
    check_state("repress");

    for (int i = 0; i < 40; i++) begin
      logic [4:0] m = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 3) == 0) glitch(m, int'($urandom_range(1, 3)));
      else press(m, int'($urandom_range(8, 20)));
      drain();
      check_state("rand");
    end

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
